// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program counter unit.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_RAS,
    PC_REDIRECT,
    PC_MRET,
    PC_TRAP
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  function automatic bit ialign_legal(input int ialign);
    return (ialign == 2) || (ialign == 4);
  endfunction

endpackage

// File: rtl/pc_unit_ras.sv
// Circular return-address stack; a push while full silently replaces the oldest entry.
module return_addr_stack
  import pc_pkg::*;
#(
  parameter int RAS_DEPTH = 4,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   tp_q, tp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [XLEN-1:0] mem_d [RAS_DEPTH];
  logic            pop_ok;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(RAS_DEPTH));
  assign top    = mem_q[tp_q];
  assign pop_ok = pop && !empty;

  always_comb begin
    tp_d  = tp_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (push && pop_ok) begin
      // Return consumes the old top while the call refills the same slot.
      mem_d[tp_q] = push_addr;
    end else if (push) begin
      tp_d        = tp_q + PW'(1);
      mem_d[tp_d] = push_addr;
      if (!full) cnt_d = cnt_q + CW'(1);
    end else if (pop_ok) begin
      tp_d  = tp_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: next-PC priority mux, trap EPC capture, flush/misaligned
// pulses and a return-address stack for predicted returns.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int              IALIGN       = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  input  logic            mret,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus,
  output logic            pc_valid,
  output logic            flush,
  output logic            misaligned,
  output logic [XLEN-1:0] epc,
  output logic            ras_empty,
  output logic            ras_full
);

  if (!ialign_legal(IALIGN)) begin : g_bad_ialign
    $error("pc_unit: IALIGN must be 2 or 4");
  end

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            flush_q, flush_d;
  logic            mis_q, mis_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] ras_top;
  logic            ras_en, hold, redir_mis;
  pc_sel_e         sel;

  assign pc_plus   = pc_q + XLEN'(IALIGN);
  assign redir_mis = redirect_valid && ((redirect_target & XLEN'(IALIGN - 1)) != '0);

  always_comb begin
    sel     = PC_SEQ;
    hold    = 1'b0;
    ras_en  = 1'b0;
    epc_d   = epc_q;
    flush_d = 1'b0;
    mis_d   = 1'b0;
    valid_d = 1'b1;
    if (trap) begin
      sel     = PC_TRAP;
      epc_d   = pc_q;
      flush_d = 1'b1;
    end else if (redir_mis) begin
      sel     = PC_TRAP;
      epc_d   = pc_q;
      flush_d = 1'b1;
      mis_d   = 1'b1;
    end else if (mret) begin
      sel     = PC_MRET;
      flush_d = 1'b1;
    end else if (redirect_valid) begin
      sel     = PC_REDIRECT;
      flush_d = 1'b1;
    end else if (stall) begin
      hold = 1'b1;
    end else begin
      ras_en = 1'b1;
      if (ras_pop && !ras_empty) sel = PC_RAS;
    end

    case (sel)
      PC_TRAP:     pc_d = TRAP_VECTOR;
      PC_MRET:     pc_d = epc_q;
      PC_REDIRECT: pc_d = redirect_target;
      PC_RAS:      pc_d = ras_top;
      default:     pc_d = hold ? pc_q : pc_plus;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
      valid_q <= valid_d;
    end
  end

  return_addr_stack #(.RAS_DEPTH(RAS_DEPTH), .XLEN(XLEN)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push && ras_en),
    .pop       (ras_pop && ras_en),
    .push_addr (ras_push_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign pc_out     = pc_q;
  assign epc        = epc_q;
  assign flush      = flush_q;
  assign misaligned = mis_q;
  assign pc_valid   = valid_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit: the driver queues the expected post-edge state,
// the monitor pops and compares it one time unit after each rising edge.
module tb_pc_unit;

  typedef enum int {
    OP_NOP, OP_RST, OP_STALL, OP_REDIR, OP_STALL_REDIR, OP_TRAP, OP_STALL_TRAP,
    OP_MRET, OP_PUSH, OP_POP, OP_PUSHPOP, OP_STALL_POP, OP_RST_TRAP
  } op_e;

  typedef struct {
    int          step;
    logic [31:0] pc;
    logic        fl;
    logic        mis;
    logic [31:0] epc;
    logic        emp;
    logic        full;
    logic        val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, trap, mret, ras_push, ras_pop;
  logic [31:0] redirect_target, ras_push_addr;
  logic [31:0] pc_out, pc_plus, epc;
  logic        pc_valid, flush, misaligned, ras_empty, ras_full;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_n = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .mret            (mret),
    .ras_push        (ras_push),
    .ras_push_addr   (ras_push_addr),
    .ras_pop         (ras_pop),
    .pc_out          (pc_out),
    .pc_plus         (pc_plus),
    .pc_valid        (pc_valid),
    .flush           (flush),
    .misaligned      (misaligned),
    .epc             (epc),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full)
  );

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %h expected %h", name, step, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc_out",     e.step, pc_out,             e.pc);
      chk("pc_plus",    e.step, pc_plus,            e.pc + 32'd4);
      chk("flush",      e.step, {31'd0, flush},     {31'd0, e.fl});
      chk("misaligned", e.step, {31'd0, misaligned},{31'd0, e.mis});
      chk("epc",        e.step, epc,                e.epc);
      chk("ras_empty",  e.step, {31'd0, ras_empty}, {31'd0, e.emp});
      chk("ras_full",   e.step, {31'd0, ras_full},  {31'd0, e.full});
      chk("pc_valid",   e.step, {31'd0, pc_valid},  {31'd0, e.val});
    end
  end

  task automatic cyc(input op_e op, input logic [31:0] arg,
                     input logic [31:0] e_pc, input logic e_fl, input logic e_mis,
                     input logic [31:0] e_epc, input logic e_emp, input logic e_full,
                     input logic e_val);
    exp_t e;
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    trap = 1'b0; mret = 1'b0; ras_push = 1'b0; ras_push_addr = '0; ras_pop = 1'b0;
    case (op)
      OP_RST:         reset = 1'b1;
      OP_STALL:       stall = 1'b1;
      OP_REDIR:       begin redirect_valid = 1'b1; redirect_target = arg; end
      OP_STALL_REDIR: begin stall = 1'b1; redirect_valid = 1'b1; redirect_target = arg; end
      OP_TRAP:        trap = 1'b1;
      OP_STALL_TRAP:  begin stall = 1'b1; trap = 1'b1; end
      OP_MRET:        mret = 1'b1;
      OP_PUSH:        begin ras_push = 1'b1; ras_push_addr = arg; end
      OP_POP:         ras_pop = 1'b1;
      OP_PUSHPOP:     begin ras_push = 1'b1; ras_push_addr = arg; ras_pop = 1'b1; end
      OP_STALL_POP:   begin stall = 1'b1; ras_pop = 1'b1; end
      OP_RST_TRAP:    begin reset = 1'b1; trap = 1'b1; end
      default: ;
    endcase
    step_n++;
    e.step = step_n; e.pc = e_pc; e.fl = e_fl; e.mis = e_mis; e.epc = e_epc;
    e.emp = e_emp; e.full = e_full; e.val = e_val;
    sb.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog step %0d actual timeout required completion", step_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    trap = 1'b0; mret = 1'b0; ras_push = 1'b0; ras_push_addr = '0; ras_pop = 1'b0;
    //   op              arg           pc            fl mis epc          emp full val
    cyc(OP_RST,         32'h0,        32'h0000_0000, 0, 0, 32'h0,       1, 0, 0);
    cyc(OP_RST,         32'h0,        32'h0000_0000, 0, 0, 32'h0,       1, 0, 0);
    cyc(OP_NOP,         32'h0,        32'h0000_0004, 0, 0, 32'h0,       1, 0, 1);
    cyc(OP_NOP,         32'h0,        32'h0000_0008, 0, 0, 32'h0,       1, 0, 1);
    cyc(OP_NOP,         32'h0,        32'h0000_000C, 0, 0, 32'h0,       1, 0, 1);
    cyc(OP_NOP,         32'h0,        32'h0000_0010, 0, 0, 32'h0,       1, 0, 1);
    cyc(OP_STALL,       32'h0,        32'h0000_0010, 0, 0, 32'h0,       1, 0, 1);
    cyc(OP_STALL,       32'h0,        32'h0000_0010, 0, 0, 32'h0,       1, 0, 1);
    cyc(OP_STALL,       32'h0,        32'h0000_0010, 0, 0, 32'h0,       1, 0, 1);
    cyc(OP_STALL_REDIR, 32'h40,       32'h0000_0040, 1, 0, 32'h0,       1, 0, 1);
    cyc(OP_NOP,         32'h0,        32'h0000_0044, 0, 0, 32'h0,       1, 0, 1);
    cyc(OP_REDIR,       32'h20,       32'h0000_0020, 1, 0, 32'h0,       1, 0, 1);
    cyc(OP_NOP,         32'h0,        32'h0000_0024, 0, 0, 32'h0,       1, 0, 1);
    cyc(OP_TRAP,        32'h0,        32'h0000_0100, 1, 0, 32'h24,      1, 0, 1);
    cyc(OP_NOP,         32'h0,        32'h0000_0104, 0, 0, 32'h24,      1, 0, 1);
    cyc(OP_MRET,        32'h0,        32'h0000_0024, 1, 0, 32'h24,      1, 0, 1);
    cyc(OP_NOP,         32'h0,        32'h0000_0028, 0, 0, 32'h24,      1, 0, 1);
    cyc(OP_REDIR,       32'h42,       32'h0000_0100, 1, 1, 32'h28,      1, 0, 1);
    cyc(OP_NOP,         32'h0,        32'h0000_0104, 0, 0, 32'h28,      1, 0, 1);
    cyc(OP_STALL_TRAP,  32'h0,        32'h0000_0100, 1, 0, 32'h104,     1, 0, 1);
    cyc(OP_NOP,         32'h0,        32'h0000_0104, 0, 0, 32'h104,     1, 0, 1);
    cyc(OP_PUSH,        32'hA0,       32'h0000_0108, 0, 0, 32'h104,     0, 0, 1);
    cyc(OP_PUSH,        32'hB0,       32'h0000_010C, 0, 0, 32'h104,     0, 0, 1);
    cyc(OP_PUSH,        32'hC0,       32'h0000_0110, 0, 0, 32'h104,     0, 0, 1);
    cyc(OP_PUSH,        32'hD0,       32'h0000_0114, 0, 0, 32'h104,     0, 1, 1);
    cyc(OP_PUSH,        32'hE0,       32'h0000_0118, 0, 0, 32'h104,     0, 1, 1);
    cyc(OP_POP,         32'h0,        32'h0000_00E0, 0, 0, 32'h104,     0, 0, 1);
    cyc(OP_POP,         32'h0,        32'h0000_00D0, 0, 0, 32'h104,     0, 0, 1);
    cyc(OP_POP,         32'h0,        32'h0000_00C0, 0, 0, 32'h104,     0, 0, 1);
    cyc(OP_POP,         32'h0,        32'h0000_00B0, 0, 0, 32'h104,     1, 0, 1);
    cyc(OP_POP,         32'h0,        32'h0000_00B4, 0, 0, 32'h104,     1, 0, 1);
    cyc(OP_PUSH,        32'h300,      32'h0000_00B8, 0, 0, 32'h104,     0, 0, 1);
    cyc(OP_PUSH,        32'h400,      32'h0000_00BC, 0, 0, 32'h104,     0, 0, 1);
    cyc(OP_PUSHPOP,     32'h500,      32'h0000_0400, 0, 0, 32'h104,     0, 0, 1);
    cyc(OP_STALL_POP,   32'h0,        32'h0000_0400, 0, 0, 32'h104,     0, 0, 1);
    cyc(OP_POP,         32'h0,        32'h0000_0500, 0, 0, 32'h104,     0, 0, 1);
    cyc(OP_POP,         32'h0,        32'h0000_0300, 0, 0, 32'h104,     1, 0, 1);
    cyc(OP_REDIR,       32'hFFFF_FFF8,32'hFFFF_FFF8, 1, 0, 32'h104,     1, 0, 1);
    cyc(OP_NOP,         32'h0,        32'hFFFF_FFFC, 0, 0, 32'h104,     1, 0, 1);
    cyc(OP_NOP,         32'h0,        32'h0000_0000, 0, 0, 32'h104,     1, 0, 1);
    cyc(OP_PUSH,        32'h600,      32'h0000_0004, 0, 0, 32'h104,     0, 0, 1);
    cyc(OP_RST_TRAP,    32'h0,        32'h0000_0000, 0, 0, 32'h0,       1, 0, 0);
    cyc(OP_NOP,         32'h0,        32'h0000_0004, 0, 0, 32'h0,       1, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", step_n, 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
